// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: sweep FSM state
// encoding and default geometry.
package regfile_pkg;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_REGBITS = 5;
    localparam int DEF_NREAD   = 2;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: hardwired zero register, writeback bypass
// and busy-bit qualification of the stored value.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic               ready,
    input  logic [REGBITS-1:0] ra,
    input  logic               regwrite,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [WIDTH-1:0]   ram_data,
    input  logic               busy_bit,
    output logic [WIDTH-1:0]   rd,
    output logic               rd_valid
);

    logic [WIDTH-1:0] rd_s;
    logic             rd_valid_s;

    // Select read data and its validity; nothing is visible until the sweep is done.
    always_comb begin
        rd_s       = {WIDTH{1'b0}};
        rd_valid_s = 1'b0;
        if (!ready) begin
            rd_s       = {WIDTH{1'b0}};
            rd_valid_s = 1'b0;
        end else if (ra == {REGBITS{1'b0}}) begin
            rd_s       = {WIDTH{1'b0}};
            rd_valid_s = 1'b1;
        end else if (regwrite && (wa == ra)) begin
            rd_s       = wd;
            rd_valid_s = 1'b1;
        end else begin
            rd_s       = ram_data;
            rd_valid_s = !busy_bit;
        end
    end

    assign rd       = rd_s;
    assign rd_valid = rd_valid_s;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NREAD combinational read ports, write-to-read bypass,
// per-register busy scoreboard with issue handshake, and a post-reset sweep
// that zeroes every entry before the block reports ready.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS,
    parameter int NREAD   = DEF_NREAD
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREAD*REGBITS-1:0] ra,
    output logic [NREAD*WIDTH-1:0]   rd,
    output logic [NREAD-1:0]         rd_valid,
    input  logic                     regwrite,
    input  logic [REGBITS-1:0]       wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic                     iss_en,
    input  logic [REGBITS-1:0]       iss_addr,
    output logic                     iss_ready,
    output logic                     ready,
    output logic [REGBITS:0]         busy_cnt
);

    localparam int DEPTH = 1 << REGBITS;

    logic [WIDTH-1:0]   ram_r [DEPTH];
    logic [DEPTH-1:0]   busy_r;
    logic [DEPTH-1:0]   busy_nxt_s;
    logic [DEPTH-1:0]   clr_mask_s;
    logic [DEPTH-1:0]   set_mask_s;
    logic               state_r;
    logic               state_nxt_s;
    logic [REGBITS-1:0] ptr_r;
    logic [REGBITS-1:0] ptr_nxt_s;
    logic [REGBITS:0]   busy_cnt_r;
    logic [REGBITS:0]   busy_cnt_nxt_s;
    logic               ready_s;
    logic               iss_ready_s;
    logic               wr_en_s;
    logic               iss_set_s;
    logic               wb_clear_s;

    assign ready_s = (state_r == ST_READY);

    // An issue may proceed if its destination is free, is r0, or is being
    // written back this very cycle (the writeback retires the old producer).
    assign iss_ready_s = ready_s && ((iss_addr == {REGBITS{1'b0}}) ||
                                     !busy_r[iss_addr] ||
                                     (regwrite && (wa == iss_addr)));

    assign wr_en_s    = ready_s && regwrite && (wa != {REGBITS{1'b0}});
    assign iss_set_s  = ready_s && iss_en && iss_ready_s && (iss_addr != {REGBITS{1'b0}});
    assign wb_clear_s = wr_en_s && busy_r[wa];

    // Clear on writeback first, then set on issue, so a same-cycle collision
    // leaves the register owned by the new producer.
    assign clr_mask_s = wr_en_s   ? ({{(DEPTH-1){1'b0}}, 1'b1} << wa)       : {DEPTH{1'b0}};
    assign set_mask_s = iss_set_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << iss_addr) : {DEPTH{1'b0}};
    assign busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;

    assign busy_cnt_nxt_s = busy_cnt_r + (REGBITS+1)'(iss_set_s) - (REGBITS+1)'(wb_clear_s);

    // Sweep FSM next state: walk every address once, then stay operational.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_INIT: begin
                ptr_nxt_s = ptr_r + REGBITS'(1'b1);
                if (ptr_r == {REGBITS{1'b1}}) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
                ptr_nxt_s   = ptr_r;
            end
            default: begin
                state_nxt_s = ST_INIT;
                ptr_nxt_s   = {REGBITS{1'b0}};
            end
        endcase
    end

    // Sweep FSM state and pointer registers; reset restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_INIT;
            ptr_r   <= {REGBITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Scoreboard bits and the running count of busy registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {(REGBITS+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Storage: zeroed by the sweep, written by writeback once operational.
    always_ff @(posedge clk) begin
        if (resetn && (state_r == ST_INIT)) begin
            ram_r[ptr_r] <= {WIDTH{1'b0}};
        end else if (resetn && wr_en_s) begin
            ram_r[wa] <= wd;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [REGBITS-1:0] ra_s;
        assign ra_s = ra[g*REGBITS +: REGBITS];

        regfile_read_port #(
            .WIDTH   (WIDTH),
            .REGBITS (REGBITS)
        ) u_port (
            .ready    (ready_s),
            .ra       (ra_s),
            .regwrite (regwrite),
            .wa       (wa),
            .wd       (wd),
            .ram_data (ram_r[ra_s]),
            .busy_bit (busy_r[ra_s]),
            .rd       (rd[g*WIDTH +: WIDTH]),
            .rd_valid (rd_valid[g])
        );
    end

    assign iss_ready = iss_ready_s;
    assign ready     = ready_s;
    assign busy_cnt  = busy_cnt_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb (4 read ports): a driver applies stimulus
// after each rising edge and queues the expected outputs computed from a
// behavioural model; a monitor compares them on the falling edge.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int RB = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR*RB-1:0]  ra = '0;
    logic [NR*W-1:0]   rd;
    logic [NR-1:0]     rd_valid;
    logic              regwrite = 1'b0;
    logic [RB-1:0]     wa = '0;
    logic [W-1:0]      wd = '0;
    logic              iss_en = 1'b0;
    logic [RB-1:0]     iss_addr = '0;
    logic              iss_ready;
    logic              ready;
    logic [RB:0]       busy_cnt;

    regfile_sb #(.WIDTH(W), .REGBITS(RB), .NREAD(NR)) dut (
        .clk(clk), .resetn(resetn), .ra(ra), .rd(rd), .rd_valid(rd_valid),
        .regwrite(regwrite), .wa(wa), .wd(wd), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ready(iss_ready), .ready(ready),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR*W-1:0] rd;
        logic [NR-1:0]   rdv;
        logic            isr;
        logic            rdy;
        logic [RB:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    // Behavioural model: architectural contents, busy set, cycles until ready.
    logic [W-1:0] mem[32];
    bit           busy_m[32];
    int           wait_m = 0;
    bit           model_valid = 1'b0;

    function automatic bit m_ready();
        return model_valid && (wait_m == 0);
    endfunction

    function automatic bit m_iss_ready();
        return m_ready() && ((iss_addr == 0) || !busy_m[iss_addr] ||
                             (regwrite && (wa == iss_addr)));
    endfunction

    // Effect of the rising edge that just sampled the current inputs.
    task automatic edge_update();
        bit acc;
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]    = '0;
                busy_m[i] = 1'b0;
            end
            wait_m      = 32;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (wait_m > 0) begin
                wait_m--;
            end else begin
                acc = iss_en && m_iss_ready();
                if (regwrite && (wa != 0)) begin
                    mem[wa]    = wd;
                    busy_m[wa] = 1'b0;
                end
                if (acc && (iss_addr != 0)) busy_m[iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        int   c;
        logic [RB-1:0] a;
        if (!model_valid) return;
        e = '0;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(busy_m[i]);
        e.cnt = (RB+1)'(c);
        e.rdy = m_ready();
        e.isr = m_iss_ready();
        for (int p = 0; p < NR; p++) begin
            a = ra[p*RB +: RB];
            if (!m_ready()) begin
                e.rd[p*W +: W] = '0;
                e.rdv[p]       = 1'b0;
            end else if (a == 0) begin
                e.rd[p*W +: W] = '0;
                e.rdv[p]       = 1'b1;
            end else if (regwrite && (wa == a)) begin
                e.rd[p*W +: W] = wd;
                e.rdv[p]       = 1'b1;
            end else begin
                e.rd[p*W +: W] = mem[a];
                e.rdv[p]       = !busy_m[a];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rn, input bit rw, input logic [RB-1:0] a_wa,
                        input logic [W-1:0] a_wd, input bit ie,
                        input logic [RB-1:0] ia, input logic [NR*RB-1:0] a_ra);
        @(posedge clk);
        #1;
        edge_update();
        resetn   = rn;
        regwrite = rw;
        wa       = a_wa;
        wd       = a_wd;
        iss_en   = ie;
        iss_addr = ia;
        ra       = a_ra;
        push_expect();
    endtask

    task automatic idle(input int n, input logic [NR*RB-1:0] a_ra);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, a_ra);
    endtask

    function automatic logic [NR*RB-1:0] pk(input logic [RB-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [NR*W-1:0] act, input logic [NR*W-1:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready",     (NR*W)'(ready),     (NR*W)'(e.rdy));
            chk("iss_ready", (NR*W)'(iss_ready), (NR*W)'(e.isr));
            chk("busy_cnt",  (NR*W)'(busy_cnt),  (NR*W)'(e.cnt));
            chk("rd_valid",  (NR*W)'(rd_valid),  (NR*W)'(e.rdv));
            chk("rd",        rd,                 e.rd);
        end
    end

    initial begin
        logic [NR*RB-1:0] rra;
        // Power-up reset and sweep.
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(34, pk(5'd0, 5'd5, 5'd1, 5'd31));
        // Write r5, then reset: the sweep must zero it again.
        step(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, pk(5'd5, 5'd0, 5'd0, 5'd0));
        idle(1, pk(5'd5, 5'd0, 5'd0, 5'd0));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, pk(5'd5, 5'd0, 5'd0, 5'd0));
        idle(34, pk(5'd5, 5'd5, 5'd0, 5'd0));
        // Issue r7, retry stalls, writeback releases it with bypass.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, pk(5'd7, 5'd7, 5'd0, 5'd0));
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, pk(5'd7, 5'd7, 5'd0, 5'd0));
        step(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd7, pk(5'd7, 5'd7, 5'd0, 5'd0));
        idle(1, pk(5'd7, 5'd0, 5'd0, 5'd0));
        // Zero register: write and issue are both harmless.
        step(1'b1, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0, pk(5'd0, 5'd0, 5'd0, 5'd0));
        idle(1, pk(5'd0, 5'd0, 5'd0, 5'd0));
        // Same-cycle writeback and re-issue of r3.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, pk(5'd3, 5'd0, 5'd0, 5'd0));
        step(1'b1, 1'b1, 5'd3, 32'h0000_0055, 1'b1, 5'd3, pk(5'd3, 5'd0, 5'd0, 5'd0));
        idle(1, pk(5'd3, 5'd0, 5'd0, 5'd0));
        // Multi-port bypass with a busy r9.
        step(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, pk(5'd9, 5'd0, 5'd0, 5'd0));
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, pk(5'd9, 5'd0, 5'd0, 5'd0));
        step(1'b1, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, '0, pk(5'd0, 5'd3, 5'd3, 5'd9));
        // Reset mid-operation with several busy registers; writes during sweep ignored.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd10, '0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd11, '0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd12, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'd13, 32'hCAFE_0000 + i, 1'b1, 5'd13, pk(5'd13, 5'd0, 5'd0, 5'd0));
        idle(31, pk(5'd13, 5'd10, 5'd0, 5'd0));
        // Randomized traffic on a small address window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NR; p++) rra[p*RB +: RB] = RB'($urandom_range(0, 7));
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 2) == 0),
                 RB'($urandom_range(0, 7)),
                 $urandom(),
                 ($urandom_range(0, 1) == 1),
                 RB'($urandom_range(0, 7)),
                 rra);
        end
        repeat (4) @(negedge clk);
        chk("drain", (NR*W)'(exp_q.size()), (NR*W)'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
